// File: rtl/pwm_ctl_pkg.sv
// Shared types and defaults for the PWM duty/phase frame loader.
// Holds the controller state encoding and the default geometry constants.
package pwm_ctl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DRAIN     = 3'd2,
        ST_COMMIT    = 3'd3,
        ST_WAIT_DONE = 3'd4
    } pwm_state_e;

    localparam int DEF_WIDTH       = 13;
    localparam int DEF_TRANS_NUM   = 249;
    localparam int DEF_RAM_LATENCY = 2;
    localparam int DEF_TIMEOUT     = 1024;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pwm_load_pipe.sv
// Valid/index delay line that follows each RAM read through the RAM latency,
// so the loader knows which shadow entry RAM_DATA belongs to. RAM_LATENCY >= 1.
module pwm_load_pipe #(
    parameter int RAM_LATENCY = 2,
    parameter int IDX_W       = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx
);

    logic [RAM_LATENCY-1:0] valid_q, valid_d;
    logic [IDX_W-1:0]       idx_q [RAM_LATENCY];
    logic [IDX_W-1:0]       idx_d [RAM_LATENCY];

    always_comb begin
        valid_d[0] = in_valid;
        idx_d[0]   = in_idx;
        for (int i = 1; i < RAM_LATENCY; i++) begin
            valid_d[i] = valid_q[i-1];
            idx_d[i]   = idx_q[i-1];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its predecessor's pre-edge value, independent of statement order.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            valid_q <= '0;
            idx_q   <= '{default: '0};
        end else begin
            valid_q <= valid_d;
            idx_q   <= idx_d;
        end
    end

    assign out_valid = valid_q[RAM_LATENCY-1];
    assign out_idx   = idx_q[RAM_LATENCY-1];

endmodule

// File: rtl/pwm_duty_loader.sv
// Frame loader: streams duty/phase for every transducer from RAM into a shadow
// bank, commits the whole bank atomically with SET, then waits for PWM_DONE.
module pwm_duty_loader
    import pwm_ctl_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int TRANS_NUM   = DEF_TRANS_NUM,
    parameter int RAM_LATENCY = DEF_RAM_LATENCY,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         START,
    output logic                         RAM_EN,
    output logic [$clog2(TRANS_NUM)-1:0] RAM_ADDR,
    input  logic [2*WIDTH-1:0]           RAM_DATA,
    output logic [WIDTH*TRANS_NUM-1:0]   DUTY_OUT,
    output logic [WIDTH*TRANS_NUM-1:0]   PHASE_OUT,
    output logic                         SET,
    input  logic                         PWM_DONE,
    output logic                         BUSY,
    output logic                         OVERRUN,
    output logic                         TIMEOUT_ERR
);

    localparam int AW = $clog2(TRANS_NUM);
    // One counter serves both the DRAIN length and the PWM_DONE wait.
    localparam int CW = $clog2(max_int(TIMEOUT, RAM_LATENCY) + 1);

    localparam logic [AW-1:0] LAST_ADDR    = AW'(TRANS_NUM - 1);
    localparam logic [CW-1:0] DRAIN_LAST   = CW'(RAM_LATENCY - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);

    pwm_state_e    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          overrun_q, overrun_d;
    logic          timeout_err_q, timeout_err_d;
    logic          commit;
    logic          timeout_hit;

    logic          pipe_valid;
    logic [AW-1:0] pipe_idx;

    logic [WIDTH-1:0] shadow_duty_q  [TRANS_NUM];
    logic [WIDTH-1:0] shadow_duty_d  [TRANS_NUM];
    logic [WIDTH-1:0] shadow_phase_q [TRANS_NUM];
    logic [WIDTH-1:0] shadow_phase_d [TRANS_NUM];
    logic [WIDTH-1:0] duty_q  [TRANS_NUM];
    logic [WIDTH-1:0] duty_d  [TRANS_NUM];
    logic [WIDTH-1:0] phase_q [TRANS_NUM];
    logic [WIDTH-1:0] phase_d [TRANS_NUM];

    // NOTE: every variable gets a default at the top of the block so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        cnt_d         = cnt_q;
        overrun_d     = overrun_q;
        timeout_err_d = timeout_err_q;
        commit        = 1'b0;
        timeout_hit   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d       = ST_FETCH;
                    addr_d        = '0;
                    overrun_d     = 1'b0;
                    timeout_err_d = 1'b0;
                end
            end
            ST_FETCH: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d = ST_COMMIT;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_COMMIT: begin
                state_d = ST_WAIT_DONE;
                cnt_d   = '0;
            end
            ST_WAIT_DONE: begin
                // Completion has priority over a coincident timeout.
                if (PWM_DONE) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d       = ST_IDLE;
                    timeout_hit   = 1'b1;
                    timeout_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (START && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    // The last RAM word lands on the same edge as the commit, so the committed
    // bank loads from the shadow's next value rather than its current one.
    always_comb begin
        shadow_duty_d  = shadow_duty_q;
        shadow_phase_d = shadow_phase_q;
        if (pipe_valid) begin
            shadow_duty_d[pipe_idx]  = RAM_DATA[WIDTH-1:0];
            shadow_phase_d[pipe_idx] = RAM_DATA[2*WIDTH-1:WIDTH];
        end
    end

    always_comb begin
        duty_d  = duty_q;
        phase_d = phase_q;
        if (commit) begin
            duty_d  = shadow_duty_d;
            phase_d = shadow_phase_d;
        end
    end

    // NOTE: both banks are flop arrays with explicit reset; a reset clause on
    // every entry also keeps synthesis from mapping them onto RAM.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q        <= ST_IDLE;
            addr_q         <= '0;
            cnt_q          <= '0;
            overrun_q      <= 1'b0;
            timeout_err_q  <= 1'b0;
            shadow_duty_q  <= '{default: '0};
            shadow_phase_q <= '{default: '0};
            duty_q         <= '{default: '0};
            phase_q        <= '{default: '0};
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            cnt_q          <= cnt_d;
            overrun_q      <= overrun_d;
            timeout_err_q  <= timeout_err_d;
            shadow_duty_q  <= shadow_duty_d;
            shadow_phase_q <= shadow_phase_d;
            duty_q         <= duty_d;
            phase_q        <= phase_d;
        end
    end

    pwm_load_pipe #(
        .RAM_LATENCY (RAM_LATENCY),
        .IDX_W       (AW)
    ) u_load_pipe (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .in_valid  (RAM_EN),
        .in_idx    (addr_q),
        .out_valid (pipe_valid),
        .out_idx   (pipe_idx)
    );

    assign RAM_EN      = (state_q == ST_FETCH);
    assign RAM_ADDR    = addr_q;
    assign SET         = (state_q == ST_COMMIT);
    assign BUSY        = (state_q != ST_IDLE);
    assign OVERRUN     = overrun_q;
    // The timeout cycle itself already reports the error.
    assign TIMEOUT_ERR = timeout_err_q | timeout_hit;

    for (genvar k = 0; k < TRANS_NUM; k++) begin : g_out
        assign DUTY_OUT[k*WIDTH +: WIDTH]  = duty_q[k];
        assign PHASE_OUT[k*WIDTH +: WIDTH] = phase_q[k];
    end

endmodule

// File: doc/pwm_duty_loader.md
PWM_DUTY_LOADER -- requirements
Module: pwm_duty_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 13, bit width of duty and phase.
REQ-002 SHALL have parameter TRANS_NUM, default 249, number of transducers loaded per frame.
REQ-003 SHALL have parameter RAM_LATENCY, default 2, cycles from RAM_ADDR/RAM_EN to valid RAM_DATA.
REQ-004 SHALL have parameter TIMEOUT, default 1024, maximum cycles to wait for PWM_DONE.
REQ-005 SHALL use one clock and an asynchronous, active-low reset; ports CLK and RST_N.
REQ-006 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-007 RST_N  input  1  asynchronous, active-low reset.
REQ-008 START  input  1  one-cycle request to load a new frame.
REQ-009 RAM_EN  output  1  read enable to the duty/phase RAM.
REQ-010 RAM_ADDR  output  $clog2(TRANS_NUM)  read address (transducer index).
REQ-011 RAM_DATA  input  2*WIDTH  {phase, duty}; duty in the low WIDTH bits.
REQ-012 DUTY_OUT  output  WIDTH x TRANS_NUM  committed duty per transducer.
REQ-013 PHASE_OUT  output  WIDTH x TRANS_NUM  committed phase per transducer.
REQ-014 SET  output  1  one-cycle commit strobe to the PWM datapath.
REQ-015 PWM_DONE  input  1  level from the PWM preconditioner: new rise/fall values ready.
REQ-016 BUSY  output  1  high in every state except IDLE.
REQ-017 OVERRUN  output  1  sticky: START seen while BUSY.
REQ-018 TIMEOUT_ERR  output  1  sticky: PWM_DONE not seen within TIMEOUT cycles.

Function
REQ-019 SHALL implement the states IDLE, FETCH, DRAIN, COMMIT and WAIT_DONE.
REQ-020 IDLE: START=1 at cycle t -> FETCH at t+1; the transition clears OVERRUN and TIMEOUT_ERR.
REQ-021 FETCH: RAM_EN=1 and RAM_ADDR=0..TRANS_NUM-1, one per cycle, over cycles t+1..t+TRANS_NUM; then DRAIN.
REQ-022 RAM_EN SHALL be 0 outside FETCH.
REQ-023 RAM_DATA for address k SHALL be captured into shadow entry k exactly RAM_LATENCY cycles after address k was issued, tracked by a RAM_LATENCY-deep valid/index delay line.
REQ-024 DRAIN SHALL last RAM_LATENCY cycles; then COMMIT.
REQ-025 COMMIT: SET=1 for exactly one cycle, at cycle t+TRANS_NUM+RAM_LATENCY+1.
REQ-026 DUTY_OUT and PHASE_OUT SHALL take all shadow values atomically, first visible in the SET cycle, and SHALL not change at any other time.
REQ-027 After COMMIT, SHALL enter WAIT_DONE, with the wait counter cleared.
REQ-028 WAIT_DONE: PWM_DONE=1 -> IDLE on the next edge.
REQ-029 WAIT_DONE: counter reaching TIMEOUT-1 without PWM_DONE -> set TIMEOUT_ERR, go to IDLE.
REQ-030 WAIT_DONE: PWM_DONE in the same cycle as the timeout -> completion wins; TIMEOUT_ERR not set.
REQ-031 START while BUSY SHALL be ignored and SHALL set OVERRUN, including START in the COMMIT cycle.
REQ-032 START in the same cycle as the WAIT_DONE -> IDLE exit SHALL be treated as BUSY (ignored, OVERRUN set).
REQ-033 RAM_ADDR SHALL hold its last value outside FETCH.
REQ-034 RAM_ADDR SHALL never exceed TRANS_NUM-1.
REQ-035 The address counter SHALL not wrap within a frame.

Reset
REQ-036 RST_N=0 SHALL immediately force state IDLE.
REQ-037 RST_N=0 SHALL clear RAM_EN, RAM_ADDR, SET, BUSY, OVERRUN, TIMEOUT_ERR, every DUTY_OUT/PHASE_OUT entry, every shadow entry, the delay line and all counters to 0.
REQ-038 Reset mid-frame SHALL abort the frame: no SET, no partial commit.
REQ-039 After reset release, a new frame SHALL need a fresh START.

Structure
REQ-040 A shared package pwm_ctl_pkg SHALL hold the state enum type and the default WIDTH/TRANS_NUM constants.
REQ-041 The RAM read valid/index delay line SHALL be one sub-module, pwm_load_pipe, parameterised by RAM_LATENCY.
REQ-042 Shadow and committed banks SHALL be separate register arrays; no RAM inference for the committed bank.

Verification (bench: TRANS_NUM=4, RAM_LATENCY=2, TIMEOUT=8)
REQ-043 Bench SHALL cover: RAM holding duty=10k+1, phase=20k+2; START at cycle 0 -> RAM_ADDR 0,1,2,3 in cycles 1-4; SET only in cycle 7; DUTY_OUT={1,11,21,31}, PHASE_OUT={2,22,42,62}.
REQ-044 Bench SHALL cover: START in cycle 3 of a frame -> OVERRUN=1, RAM_ADDR sequence unchanged, one SET only; next accepted START clears OVERRUN.
REQ-045 Bench SHALL cover: PWM_DONE held 0 after SET -> TIMEOUT_ERR=1 8 cycles after SET; BUSY=0 next cycle.
REQ-046 Bench SHALL cover: PWM_DONE rising exactly on the timeout cycle -> TIMEOUT_ERR stays 0.
REQ-047 Bench SHALL cover: RST_N low during cycle 5 (DRAIN) with DUTY_OUT previously {1,11,21,31} -> all outputs 0, no SET; START after release -> normal frame.
REQ-048 Bench SHALL cover: back-to-back frames with new RAM contents, PWM_DONE 2 cycles after each SET -> DUTY_OUT steady between SET pulses and correct after each.
